// File: rtl/fifo_stream_drain.sv
`default_nettype none
// fifo_stream_drain: drains a synchronous FIFO into a 2-entry skid buffer and
// presents the words as a packet-framed valid/ready stream.  Rev 1.0
module fifo_stream_drain #(
  parameter int FIFO_WIDTH = 16,
  parameter int PKT_LEN    = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [CNT_W-1:0]      words_out,
  output logic                  err_underflow
);

  localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

  logic [1:0]            count;
  logic                  rd_pend;
  logic [FIFO_WIDTH-1:0] head;
  logic [FIFO_WIDTH-1:0] tail;
  logic [BEAT_W-1:0]     beat_cnt;
  logic [CNT_W-1:0]      word_cnt;
  logic                  err;
  logic                  pop;
  logic                  capture;
  logic [2:0]            occupancy;

  assign m_valid   = (count != 2'd0);
  assign pop       = m_valid && m_ready;
  assign capture   = rd_pend && !fifo_underflow;
  assign occupancy = {1'b0, count} + {2'b00, rd_pend};

  // Counting this cycle's pop as free space keeps one beat per cycle in steady state.
  assign fifo_rd_en = !rst && !fifo_empty && (occupancy < (3'd2 + {2'b00, pop}));

  assign m_data        = head;
  assign m_last        = m_valid && (beat_cnt == LAST_BEAT);
  assign words_out     = word_cnt;
  assign err_underflow = err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case ({capture, pop})
        2'b10: begin
          if (count == 2'd0) head <= fifo_data_out;
          else               tail <= fifo_data_out;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Head leaves and the returning word joins at the tail; occupancy is unchanged.
          if (count == 2'd1) begin
            head <= fifo_data_out;
          end else begin
            head <= tail;
            tail <= fifo_data_out;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend  <= 1'b0;
      beat_cnt <= '0;
      word_cnt <= '0;
      err      <= 1'b0;
    end else begin
      rd_pend <= fifo_rd_en;
      if (rd_pend && fifo_underflow) err <= 1'b1;
      if (pop) begin
        word_cnt <= word_cnt + CNT_W'(1);
        beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + BEAT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_drain.sv
`default_nettype none
// tb_fifo_stream_drain: randomized scoreboard bench with a queue-based FIFO model
// driving two instances (default framing and PKT_LEN=1/CNT_W=4).  Rev 1.0
module tb_fifo_stream_drain;

  localparam int W     = 16;
  localparam int PKT   = 4;
  localparam int CW    = 16;
  localparam int CW_B  = 4;
  localparam int MAXW  = 1024;

  logic            clk = 1'b0;
  logic            rst;
  logic            fifo_empty;
  logic [W-1:0]    fifo_data_out;
  logic            fifo_underflow;
  logic            m_ready;
  logic            rd_en_a, rd_en_b;
  logic [W-1:0]    m_data_a, m_data_b;
  logic            m_valid_a, m_valid_b, m_last_a, m_last_b;
  logic [CW-1:0]   words_a;
  logic [CW_B-1:0] words_b;
  logic            err_a, err_b;

  always #5 clk = ~clk;

  fifo_stream_drain #(.FIFO_WIDTH(W), .PKT_LEN(PKT), .CNT_W(CW)) dut_a (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data_out(fifo_data_out),
    .fifo_underflow(fifo_underflow), .fifo_rd_en(rd_en_a), .m_data(m_data_a),
    .m_valid(m_valid_a), .m_ready(m_ready), .m_last(m_last_a),
    .words_out(words_a), .err_underflow(err_a));

  fifo_stream_drain #(.FIFO_WIDTH(W), .PKT_LEN(1), .CNT_W(CW_B)) dut_b (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data_out(fifo_data_out),
    .fifo_underflow(fifo_underflow), .fifo_rd_en(rd_en_b), .m_data(m_data_b),
    .m_valid(m_valid_b), .m_ready(m_ready), .m_last(m_last_b),
    .words_out(words_b), .err_underflow(err_b));

  logic [W-1:0] mem [MAXW];
  bit           dropped [MAXW];
  int           next_id = 0;
  int           fifo_q[$];
  int           exp_q[$];
  int           tests = 0;
  int           fails = 0;
  int           reads = 0;
  int           inject_read = -1;
  bit           exp_err = 1'b0;
  int           acc = 0;
  int           exp_words = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int pending();
    int n = 0;
    foreach (exp_q[i]) if (!dropped[exp_q[i]]) n++;
    return n;
  endfunction

  task automatic push_word(input logic [W-1:0] v);
    mem[next_id]     = v;
    dropped[next_id] = 1'b0;
    fifo_q.push_back(next_id);
    exp_q.push_back(next_id);
    next_id++;
    exp_words++;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input bit random_ready);
    int budget = 400;
    while ((pending() != 0 || m_valid_a || fifo_q.size() != 0) && budget > 0) begin
      if (random_ready) m_ready = 1'($urandom_range(0, 1));
      cyc(1);
      budget--;
    end
    m_ready = 1'b1;
    if (budget == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: drain timeout, %0d words outstanding", name, pending());
    end
  endtask

  // FIFO model: read decided mid-cycle, data returned one cycle after the read edge.
  initial begin
    bit rd;
    int id;
    fifo_empty     = 1'b1;
    fifo_data_out  = '0;
    fifo_underflow = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      rd = rd_en_a;
      if (fifo_q.size() == 0) check("rd_en_while_empty", rd_en_a, 0);
      check("rd_en_match", rd_en_b, rd_en_a);
      @(posedge clk);
      #1;
      if (fifo_underflow && !rst) exp_err = 1'b1;
      fifo_underflow = 1'b0;
      if (rd && fifo_q.size() > 0) begin
        id = fifo_q.pop_front();
        reads++;
        fifo_data_out = mem[id];
        if (reads == inject_read) begin
          fifo_underflow = 1'b1;
          dropped[id]    = 1'b1;
          exp_words--;
        end
      end
      #1 fifo_empty = (fifo_q.size() == 0);
    end
  end

  // Monitor: compares every presented/accepted beat against the scoreboard.
  initial begin
    bit           stalled = 1'b0;
    logic [W-1:0] stall_data;
    logic         stall_last;
    int           id;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        acc     = 0;
        exp_err = 1'b0;
        stalled = 1'b0;
        check("rst_m_valid", m_valid_a, 0);
        check("rst_m_last", m_last_a, 0);
        check("rst_m_data", m_data_a, 0);
        check("rst_words", words_a, 0);
        check("rst_err", err_a, 0);
        check("rst_rd_en", rd_en_a, 0);
        check("rst_m_valid_b", m_valid_b, 0);
      end else begin
        check("words_out", words_a, acc % (1 << CW));
        check("words_out_b", words_b, acc % (1 << CW_B));
        check("err_underflow", err_a, exp_err);
        check("err_underflow_b", err_b, exp_err);
        check("m_valid_b", m_valid_b, m_valid_a);
        check("m_last_b", m_last_b, m_valid_b);
        check("m_last", m_last_a, m_valid_a && ((acc % PKT) == PKT - 1));
        if (dut_a.count > 2'd2) check("count_le_2", dut_a.count, 2);
        if (stalled) begin
          check("stall_valid", m_valid_a, 1);
          check("stall_data", m_data_a, stall_data);
          check("stall_last", m_last_a, stall_last);
        end
        if (m_valid_a && m_ready) begin
          while (exp_q.size() > 0 && dropped[exp_q[0]]) void'(exp_q.pop_front());
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_beat: got %0h, expected no beat", m_data_a);
          end else begin
            id = exp_q.pop_front();
            check("m_data", m_data_a, mem[id]);
            check("m_data_b", m_data_b, mem[id]);
          end
          acc++;
          stalled = 1'b0;
        end else begin
          stalled    = m_valid_a;
          stall_data = m_data_a;
          stall_last = m_last_a;
        end
      end
    end
  end

  initial begin
    int r0;
    int budget;
    rst     = 1'b1;
    m_ready = 1'b0;
    cyc(3);
    rst     = 1'b0;

    // Preload 1..8 with a ready sink: latency and back-to-back framing.
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push_word(W'(i));
    budget = 20;
    do begin
      @(negedge clk);
      #3;
      budget--;
    end while (!rd_en_a && budget > 0);
    check("first_rd_en_seen", rd_en_a, 1);
    @(negedge clk); #3;
    check("latency_edge1_valid", m_valid_a, 0);
    @(negedge clk); #3;
    check("latency_edge2_valid", m_valid_a, 1);
    check("latency_first_data", m_data_a, 16'h0001);
    cyc(1);
    wait_drain("p1_drain", 1'b0);
    check("p1_words", words_a, 8);
    check("p1_err", err_a, 0);

    // Stalled sink: only two reads fit, head stays at the first word.
    m_ready = 1'b0;
    r0 = reads;
    for (int i = 1; i <= 8; i++) push_word(W'(i));
    cyc(10);
    check("p2_reads", reads - r0, 2);
    check("p2_head", m_data_a, 16'h0001);
    check("p2_count", dut_a.count, 2);
    m_ready = 1'b1;
    wait_drain("p2_drain", 1'b0);
    check("p2_words", words_a, exp_words);

    // Alternating ready with random data.
    for (int i = 0; i < 16; i++) push_word(W'($urandom));
    budget = 200;
    while ((pending() != 0 || m_valid_a) && budget > 0) begin
      m_ready = ~m_ready;
      cyc(1);
      budget--;
    end
    wait_drain("p3_drain", 1'b0);
    check("p3_words", words_a, exp_words);

    // Underflow on the third read of this burst.
    inject_read = reads + 3;
    for (int i = 0; i < 24; i++) push_word(W'($urandom));
    wait_drain("p4_drain", 1'b1);
    check("p4_words", words_a, exp_words);
    check("p4_err_sticky", err_a, 1);
    inject_read = -1;

    // Reset while words are buffered and in flight.
    for (int i = 0; i < 8; i++) push_word(W'($urandom));
    m_ready = 1'b0;
    cyc(4);
    check("p5_count_before", dut_a.count, 2);
    @(negedge clk);
    #1;
    rst       = 1'b1;
    exp_q     = fifo_q;
    exp_words = fifo_q.size();
    #2;
    check("p5_beat_cnt", dut_a.beat_cnt, 0);
    check("p5_count", dut_a.count, 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    cyc(1);
    m_ready = 1'b1;
    wait_drain("p5_drain", 1'b0);
    check("p5_words", words_a, exp_words);
    check("p5_err_cleared", err_a, 0);

    // Wrap of the narrow counter: 18 beats leave it at 2.
    @(negedge clk);
    #1;
    rst       = 1'b1;
    exp_words = 0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    cyc(1);
    for (int i = 0; i < 18; i++) push_word(W'($urandom));
    wait_drain("p6_drain", 1'b0);
    check("p6_words_b", words_b, 2);
    check("p6_words_a", words_a, 18);

    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
